ahb_slave_mem: RTL
==================

# ahb_slave_mem

AHB-Lite memory-mapped slave that sits directly downstream of `ahb_master`, consuming its `sel`/`haddr`/`hwrite`/`hsize`/`htrans`/`hready`/`hwdata` outputs. It returns `hreadyout`/`hresp`/`hrdata`. It provides a word-organised RAM with byte-lane writes, programmable wait states, and a two-cycle ERROR response for illegal accesses. One instance is placed per slave slot, selected by its `SLAVE_ID`.

## Interface
- `SLAVE_ID`, 2'b00, value of `sel` that selects this instance
- `DEPTH`, 256, number of 32-bit words; legal word index 0..DEPTH-1
- `WAIT_STATES`, 0, extra data-phase cycles with `hreadyout`=0 (0..15)
- `hclk` input 1 — single clock, all logic on rising edge
- `hresetn` input 1 — reset, synchronous, active-low
- `sel` input 2 — slave select from master
- `haddr` input 32 — byte address, address phase
- `hwrite` input 1 — 1 = write
- `hsize` input 3 — 000 byte, 001 halfword, 010 word
- `htrans` input 2 — 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- `hready` input 1 — bus ready; an address phase is accepted only when high
- `hwdata` input 32 — write data, data phase
- `hreadyout` output 1 — slave ready
- `hresp` output 1 — 0 OKAY, 1 ERROR
- `hrdata` output 32 — read data, valid in the data-phase cycle with `hreadyout`=1

## Operation
- Accept: on a rising edge, `sel`==SLAVE_ID && `hready` && `htrans`[1]==1. The block registers `haddr`, `hwrite`, and `hsize`. IDLE/BUSY are ignored, and the response stays OKAY with zero wait.
- Illegal access (checked at accept): word index `haddr`[31:2] >= DEPTH; `hsize` > 010; halfword with `haddr`[0]=1; word with `haddr`[1:0]!=0.
- FSM states:
  - IDLE: `hreadyout`=1, `hresp`=0.
    - Legal accept → WAIT if WAIT_STATES>0, else XFER.
    - Illegal accept → ERR1.
  - WAIT: `hreadyout`=0, `hresp`=0. The wait counter is loaded with WAIT_STATES at accept and decrements each cycle. The state goes to XFER when the counter reaches 1.
  - XFER: `hreadyout`=1, `hresp`=0. The data phase completes at the end of this cycle.
    - New accept → WAIT, XFER or ERR1 (pipelined).
    - Otherwise → IDLE.
  - ERR1: `hreadyout`=0, `hresp`=1 → ERR2.
  - ERR2: `hreadyout`=1, `hresp`=1. Memory is untouched. New accept → as from IDLE; otherwise → IDLE.
- Write: committed at the XFER edge using `hwdata` of that cycle. Byte enables come from the registered `hsize` and address[1:0]:
  - byte: lane = addr[1:0]
  - halfword: lanes {addr[1],0} and {addr[1],1}
  - word: all lanes
- Read: `hrdata` is registered. It is loaded from RAM at the last edge before XFER, so it is valid throughout XFER. All four lanes are returned regardless of `hsize`.
- `hrdata` is 0 outside read XFER cycles.
- Read-after-write forwarding: a read accepted on the same edge that a write commits to the same word returns the merged post-write word, never stale data.

## Timing
- Reset (`hresetn`=0 at a rising edge) sets: FSM=IDLE, `hreadyout`=1, `hresp`=0, `hrdata`=0, wait counter=0, registered address/control=0.
- RAM contents are not reset.
- Reset mid-transfer abandons the transfer; a write not yet at its XFER edge is not committed.
- Latency, accept to data-phase completion:
  - OKAY: 1+WAIT_STATES cycles.
  - ERROR: 2 cycles.
- Back-to-back accepts are supported at full rate with WAIT_STATES=0.
- `hreadyout`=0 stalls the bus, so no new accept can occur during WAIT or ERR1.

## Structure
- Shared package `ahb_pkg`: HTRANS codes (IDLE, BUSY, NONSEQ, SEQ), HSIZE codes (BYTE, HALF, WORD), HRESP codes (OKAY, ERROR), and the FSM state typedef.
- Sub-module `ahb_slave_ram`:
  - DEPTH×32 array.
  - Synchronous write with 4-bit byte enable.
  - Read port containing the forwarding mux.
- The FSM, wait counter and legality checks live in the top level.

## Test plan
- WAIT_STATES=0: word write 0xDEADBEEF to 0x10, then read 0x10 → XFER with `hreadyout`=1, `hrdata`=0xDEADBEEF, `hresp`=0.
- WAIT_STATES=3: read accept → `hreadyout` low for exactly 3 cycles, then high with correct data.
- Byte write 0xAA to 0x13 over 0x11223344 → readback 0xAA223344; halfword 0x5566 to 0x12 → 0x55663344.
- Each illegal access → ERR1 (`hreadyout`=0, `hresp`=1) then ERR2 (`hreadyout`=1, `hresp`=1), memory unchanged. Cases:
  - address DEPTH*4
  - misaligned word at 0x02
  - `hsize`=011
- Pipelined write 0x12345678 to 0x20 with a read of 0x20 accepted at the write's XFER edge → read returns 0x12345678.
- `hresetn` low during WAIT of a write → next cycle `hreadyout`=1, `hresp`=0, `hrdata`=0; readback shows the old word. IDLE/BUSY with `sel` matching → no state change.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the slave FSM state type.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_XFER = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } slv_state_e;

    // Byte lanes touched by a legal access of the given size at byte offset lane.
    function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] lane);
        case (size)
            HSIZE_BYTE: byte_en = 4'b0001 << lane;
            HSIZE_HALF: byte_en = lane[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: byte_en = 4'b1111;
            default:    byte_en = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/ahb_slave_ram.sv
// Word-organised RAM with byte-lane writes; the read port forwards a same-edge write.
module ahb_slave_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          i_clk,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_widx,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_ridx,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_be[b]) begin
                r_mem[i_widx][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    // A read sampled on the same edge as a write to that word sees the merged word.
    always_comb begin
        o_rdata = r_mem[i_ridx];
        if (i_widx == i_ridx) begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b]) begin
                    o_rdata[8*b +: 8] = i_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite memory slave: address-phase legality check, wait-state FSM,
// two-cycle ERROR response and a registered read data path.
module ahb_slave_mem
    import ahb_pkg::*;
#(
    parameter logic [1:0] SLAVE_ID    = 2'b00,
    parameter int         DEPTH       = 256,
    parameter int         WAIT_STATES = 0
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic [1:0]  sel,
    input  logic [31:0] haddr,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [1:0]  htrans,
    input  logic        hready,
    input  logic [31:0] hwdata,
    output logic        hreadyout,
    output logic        hresp,
    output logic [31:0] hrdata,
    output logic [2:0]  o_dbg_state
);

    localparam int         AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    slv_state_e    r_state;
    slv_state_e    w_next;
    logic [AW-1:0] r_idx;
    logic [1:0]    r_lane;
    logic          r_write;
    logic [2:0]    r_size;
    logic [3:0]    r_cnt;

    logic          w_take;
    logic          w_illegal;
    logic          w_rd_load;
    logic [3:0]    w_be;
    logic [AW-1:0] w_ridx;
    logic [31:0]   w_ram_rdata;

    // Handshake: an address phase transfers on a rising edge where hready is high
    // and this slave is selected with NONSEQ/SEQ; the data phase ends on the first
    // edge where hreadyout is high, so hreadyout low holds the whole bus.
    assign w_take = hready && (sel == SLAVE_ID)
                 && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ)
                 && (r_state == ST_IDLE || r_state == ST_XFER || r_state == ST_ERR2);

    assign w_illegal = (haddr[31:2] >= 30'(DEPTH))
                    || (hsize > HSIZE_WORD)
                    || (hsize == HSIZE_HALF && haddr[0])
                    || (hsize == HSIZE_WORD && haddr[1:0] != 2'b00);

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        hreadyout = 1'b1;
        hresp     = HRESP_OKAY;
        case (r_state)
            ST_WAIT: begin
                hreadyout = 1'b0;
                if (r_cnt <= 4'd1) begin
                    w_next = ST_XFER;
                end
            end
            ST_ERR1: begin
                hreadyout = 1'b0;
                hresp     = HRESP_ERROR;
                w_next    = ST_ERR2;
            end
            default: begin
                // IDLE, XFER and ERR2 all complete in this cycle and may take a new phase.
                if (r_state == ST_ERR2) begin
                    hresp = HRESP_ERROR;
                end
                if (!w_take) begin
                    w_next = ST_IDLE;
                end else if (w_illegal) begin
                    w_next = ST_ERR1;
                end else if (WS != 4'd0) begin
                    w_next = ST_WAIT;
                end else begin
                    w_next = ST_XFER;
                end
            end
        endcase
    end

    assign o_dbg_state = r_state;

    assign w_be = (hresetn && r_state == ST_XFER && r_write) ? byte_en(r_size, r_lane) : 4'b0000;

    // hrdata is captured on the edge that enters XFER, from the bus address when
    // there are no wait states and from the registered address otherwise.
    assign w_rd_load = (w_next == ST_XFER) && ((r_state == ST_WAIT) ? !r_write : !hwrite);
    assign w_ridx    = (r_state == ST_WAIT) ? r_idx : haddr[AW+1:2];

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            r_idx   <= '0;
            r_lane  <= 2'b00;
            r_write <= 1'b0;
            r_size  <= 3'b000;
            r_cnt   <= 4'd0;
            hrdata  <= 32'h0;
        end else begin
            if (w_take) begin
                r_idx   <= haddr[AW+1:2];
                r_lane  <= haddr[1:0];
                r_write <= hwrite;
                r_size  <= hsize;
                r_cnt   <= WS;
            end else if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            hrdata <= w_rd_load ? w_ram_rdata : 32'h0;
        end
    end

    ahb_slave_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .i_clk   (hclk),
        .i_be    (w_be),
        .i_widx  (r_idx),
        .i_wdata (hwdata),
        .i_ridx  (w_ridx),
        .o_rdata (w_ram_rdata)
    );

endmodule
